// File: rtl/lif_syn_pkg.sv
// rtl/lif_syn_pkg.sv - shared types, sizes and clamp helper for the LIF synaptic driver
package lif_syn_pkg;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int LIF_N_SYN     = 8;
  localparam int LIF_W_WIDTH   = 4;
  localparam int LIF_CUR_WIDTH = 8;
  localparam int SUM_WIDTH     = LIF_CUR_WIDTH + $clog2(LIF_N_SYN) + 2;
  localparam int CUR_MAX       = (1 << LIF_CUR_WIDTH) - 1;

  // Saturates a signed value into 0..hi.
  function automatic int clamp(input int v, input int hi);
    if (v < 0)
      return 0;
    else if (v > hi)
      return hi;
    else
      return v;
  endfunction

endpackage

// File: rtl/lif_syn_wsum.sv
// rtl/lif_syn_wsum.sv - masked signed sum of synapse weights
// Combinational; each weight contributes only while its spike line is high.
module lif_syn_wsum
  import lif_syn_pkg::*;
#(
  parameter int N_SYN   = LIF_N_SYN,
  parameter int W_WIDTH = LIF_W_WIDTH,
  parameter int SUM_W   = SUM_WIDTH
) (
  input  logic [N_SYN-1:0]         i_spike,
  input  logic [N_SYN*W_WIDTH-1:0] i_weights,
  output logic signed [SUM_W-1:0]  o_sum
);

  always_comb begin
    o_sum = '0;
    for (int i = 0; i < N_SYN; i++) begin
      if (i_spike[i])
        o_sum = o_sum + SUM_W'($signed(i_weights[i*W_WIDTH +: W_WIDTH]));
    end
  end

endmodule

// File: rtl/lif_syn_driver.sv
// rtl/lif_syn_driver.sv - programmable synaptic front end producing the LIF neuron input current
// Weights load through a beat stream; in RUN the current leaks, integrates spikes and saturates.
module lif_syn_driver
  import lif_syn_pkg::*;
#(
  parameter int N_SYN       = LIF_N_SYN,
  parameter int W_WIDTH     = LIF_W_WIDTH,
  parameter int CUR_WIDTH   = LIF_CUR_WIDTH,
  parameter int DECAY_SHIFT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_SYN-1:0]     i_spike_in,
  input  logic                 i_cfg_start,
  input  logic                 i_wload_valid,
  input  logic [W_WIDTH-1:0]   i_wload_data,
  output logic                 o_wload_ready,
  output logic                 o_run,
  output logic [CUR_WIDTH-1:0] o_current,
  output logic                 o_sat_hi,
  output logic                 o_sat_lo
);

  localparam int PTR_W = (N_SYN > 1) ? $clog2(N_SYN) : 1;
  localparam int ACC_W = ((CUR_WIDTH > W_WIDTH) ? CUR_WIDTH : W_WIDTH) + $clog2(N_SYN) + 2;
  localparam int CMAX  = (1 << CUR_WIDTH) - 1;
  localparam logic [PTR_W-1:0]        PTR_LAST = PTR_W'(N_SYN - 1);
  localparam logic [PTR_W-1:0]        PTR_ONE  = PTR_W'(1);
  localparam logic signed [ACC_W-1:0] ACC_ONE  = ACC_W'(1);
  localparam logic signed [ACC_W-1:0] ACC_MAX  = ACC_W'(CMAX);

  state_t                 r_state;
  logic [PTR_W-1:0]       r_ptr;
  logic [CUR_WIDTH-1:0]   r_acc;
  logic                   r_sat_hi;
  logic                   r_sat_lo;
  logic [W_WIDTH-1:0]     r_weight [N_SYN];

  logic [N_SYN*W_WIDTH-1:0] w_wflat;
  logic signed [ACC_W-1:0]  w_syn;
  logic signed [ACC_W-1:0]  w_acc_ext;
  logic signed [ACC_W-1:0]  w_shift;
  logic signed [ACC_W-1:0]  w_leak;
  logic signed [ACC_W-1:0]  w_nxt;

  for (genvar g = 0; g < N_SYN; g++) begin : g_flat
    assign w_wflat[g*W_WIDTH +: W_WIDTH] = r_weight[g];
  end

  lif_syn_wsum #(
    .N_SYN   (N_SYN),
    .W_WIDTH (W_WIDTH),
    .SUM_W   (ACC_W)
  ) u_wsum (
    .i_spike   (i_spike_in),
    .i_weights (w_wflat),
    .o_sum     (w_syn)
  );

  assign w_acc_ext = {{(ACC_W-CUR_WIDTH){1'b0}}, r_acc};
  assign w_shift   = w_acc_ext >>> DECAY_SHIFT;

  // Leak never drops below 1 while nonzero so an idle current always reaches 0.
  always_comb begin
    w_leak = '0;
    if (r_acc != '0)
      w_leak = (w_shift == '0) ? ACC_ONE : w_shift;
  end

  assign w_nxt = w_acc_ext - w_leak + w_syn;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= LOAD;
      r_ptr    <= '0;
      r_acc    <= '0;
      r_sat_hi <= 1'b0;
      r_sat_lo <= 1'b0;
      for (int i = 0; i < N_SYN; i++)
        r_weight[i] <= '0;
    end else if (i_cfg_start) begin
      r_state  <= LOAD;
      r_ptr    <= '0;
      r_acc    <= '0;
      r_sat_hi <= 1'b0;
      r_sat_lo <= 1'b0;
    end else begin
      case (r_state)
        LOAD: begin
          r_acc    <= '0;
          r_sat_hi <= 1'b0;
          r_sat_lo <= 1'b0;
          if (i_wload_valid) begin
            r_weight[r_ptr] <= i_wload_data;
            if (r_ptr == PTR_LAST) begin
              r_ptr   <= '0;
              r_state <= RUN;
            end else begin
              r_ptr <= r_ptr + PTR_ONE;
            end
          end
        end
        RUN: begin
          r_acc    <= CUR_WIDTH'(clamp(32'(w_nxt), CMAX));
          r_sat_hi <= (w_nxt > ACC_MAX);
          r_sat_lo <= w_nxt[ACC_W-1];
        end
        default: r_state <= LOAD;
      endcase
    end
  end

  assign o_wload_ready = (r_state == LOAD);
  assign o_run         = (r_state == RUN);
  assign o_current     = r_acc;
  assign o_sat_hi      = r_sat_hi;
  assign o_sat_lo      = r_sat_lo;

endmodule

// File: tb/tb_lif_syn_driver.sv
// tb/tb_lif_syn_driver.sv - directed self-checking bench for lif_syn_driver
module tb_lif_syn_driver;

  logic       clk;
  logic       rst;

  logic [7:0] spike_a, spike_b;
  logic       cfg_a, cfg_b;
  logic       val_a, val_b;
  logic [3:0] data_a, data_b;
  logic       ready_a, ready_b;
  logic       run_a, run_b;
  logic [7:0] cur_a, cur_b;
  logic       shi_a, shi_b;
  logic       slo_a, slo_b;

  int n_checks = 0;
  int n_fail   = 0;

  int wa [8] = '{7, -8, 3, 0, 1, 2, -1, 4};
  int wr [8] = '{1, -8, 3, 0, 1, 2, -1, 4};
  int eb [6] = '{56, 109, 159, 206, 250, 255};

  lif_syn_driver u_a (
    .clk           (clk),
    .rst           (rst),
    .i_spike_in    (spike_a),
    .i_cfg_start   (cfg_a),
    .i_wload_valid (val_a),
    .i_wload_data  (data_a),
    .o_wload_ready (ready_a),
    .o_run         (run_a),
    .o_current     (cur_a),
    .o_sat_hi      (shi_a),
    .o_sat_lo      (slo_a)
  );

  lif_syn_driver #(.DECAY_SHIFT(4)) u_b (
    .clk           (clk),
    .rst           (rst),
    .i_spike_in    (spike_b),
    .i_cfg_start   (cfg_b),
    .i_wload_valid (val_b),
    .i_wload_data  (data_b),
    .o_wload_ready (ready_b),
    .o_run         (run_b),
    .o_current     (cur_b),
    .o_sat_hi      (shi_b),
    .o_sat_lo      (slo_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat_a(input int d);
    val_a  = 1'b1;
    data_a = 4'(d);
    step();
    val_a  = 1'b0;
  endtask

  task automatic beat_b(input int d);
    val_b  = 1'b1;
    data_b = 4'(d);
    step();
    val_b  = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    spike_a = '0; cfg_a = 1'b0; val_a = 1'b0; data_a = '0;
    spike_b = '0; cfg_b = 1'b0; val_b = 1'b0; data_b = '0;
    step();
    step();
    rst = 1'b0;

    check("rst_current", cur_a, 0);
    check("rst_ready", ready_a, 1);
    check("rst_run", run_a, 0);
    check("rst_sat_hi", shi_a, 0);
    check("rst_sat_lo", slo_a, 0);

    spike_a = 8'hFF;
    step(); step(); step();
    check("load_spike_ignored", cur_a, 0);
    check("load_still_load", run_a, 0);
    spike_a = 8'h00;

    for (int i = 0; i < 8; i++) begin
      beat_a(wa[i]);
      if (i < 7) check("run_early", run_a, 0);
      if (i % 2 == 0) step();
    end
    check("run_after_8", run_a, 1);
    check("ready_after_8", ready_a, 0);

    spike_a = 8'b0000_0001;
    step(); check("int_7", cur_a, 7);
    step(); check("int_13", cur_a, 13);
    step(); check("int_17", cur_a, 17);
    spike_a = 8'h00;
    step(); check("decay_13", cur_a, 13);
    spike_a = 8'b0000_0010;
    step(); check("neg_2", cur_a, 2);
    check("neg_2_sat_lo", slo_a, 0);
    step(); check("neg_clamp_0", cur_a, 0);
    check("neg_sat_lo", slo_a, 1);
    spike_a = 8'h00;
    step(); check("sat_lo_cleared", slo_a, 0);
    check("idle_0", cur_a, 0);

    spike_a = 8'b0000_0001;
    step(); check("re_7", cur_a, 7);
    step(); check("re_13", cur_a, 13);
    spike_a = 8'b0000_0010;
    step(); check("re_2", cur_a, 2);
    spike_a = 8'h00;
    step(); check("min_leak_1", cur_a, 1);
    step(); check("min_leak_0", cur_a, 0);
    step(); check("stay_0", cur_a, 0);

    spike_a = 8'b0000_0001;
    step(); check("pre_cfg_7", cur_a, 7);
    cfg_a = 1'b1;
    step();
    cfg_a = 1'b0;
    check("cfg_a_current", cur_a, 0);
    check("cfg_a_run", run_a, 0);
    check("cfg_a_ready", ready_a, 1);

    beat_a(5);
    cfg_a = 1'b1; val_a = 1'b1; data_a = 4'(-3);
    step();
    cfg_a = 1'b0; val_a = 1'b0;
    check("cfg_beat_ready", ready_a, 1);

    spike_a = 8'b0000_0010;
    for (int i = 0; i < 8; i++) begin
      beat_a(wr[i]);
      if (i < 7) check("reload_run_early", run_a, 0);
    end
    check("reload_run", run_a, 1);
    step();
    check("kept_w1_current", cur_a, 0);
    check("kept_w1_sat_lo", slo_a, 1);
    spike_a = 8'b0000_0001;
    step();
    check("new_w0", cur_a, 1);
    check("new_w0_sat_lo", slo_a, 0);

    for (int i = 0; i < 8; i++) beat_b(7);
    check("b_run", run_b, 1);
    spike_b = 8'hFF;
    for (int i = 0; i < 6; i++) begin
      step();
      check("b_current", cur_b, eb[i]);
      check("b_sat_hi", shi_b, (i == 5) ? 1 : 0);
    end

    cfg_b = 1'b1;
    step();
    cfg_b = 1'b0;
    check("b_cfg_current", cur_b, 0);
    for (int i = 0; i < 8; i++) beat_b(7);
    step(); step(); step();
    check("b_159", cur_b, 159);
    cfg_b = 1'b1;
    step();
    cfg_b = 1'b0;
    check("b_cfg159_current", cur_b, 0);
    check("b_cfg159_run", run_b, 0);
    check("b_cfg159_ready", ready_b, 1);
    check("b_cfg159_sat_hi", shi_b, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
